uart_tx_feeder: RTL and testbench

Byte buffer and scheduler sitting directly upstream of the UART transmitter. Accepts bytes from the I2C EEPROM read path (or any producer) as single-cycle strobes and stores them in a synchronous FIFO. Drains the FIFO into the transmitter one byte at a time, issuing a one-cycle tx_byte_vld only when the transmitter reports not busy.

---
 rtl/uart_tx_feeder_pkg.sv | 27 ++
 rtl/uart_tx_feeder_if.sv | 28 ++
 rtl/uart_tx_feeder_fifo.sv | 60 ++++++
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 tb/tb_uart_tx_feeder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared defaults, ASCII constants and FSM encodings for the UART TX feeder.
// UART_FEEDER_HEX_ASCII_EN adds the hex-ASCII states and nibble encoder.
package uart_tx_feeder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int AW_DEF     = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND    = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;

`ifdef UART_FEEDER_HEX_ASCII_EN
    localparam logic [2:0] ST_SEND_LO = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    // 'A' (0x41) minus 10, so nibble A..F lands on 0x41..0x46
    localparam logic [7:0] ASCII_ALPHA_OFS  = 8'h37;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? ASCII_DIGIT_BASE + {4'h0, nib}
                             : ASCII_ALPHA_OFS  + {4'h0, nib};
    endfunction
`endif

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-side signal bundle of the UART TX feeder.
interface uart_tx_feeder_if
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              full;
    logic              empty;
    logic [AW:0]       usedw;
    logic              overflow;
    logic              ovf_clr;
    logic              tx_busy;
    logic              tx_byte_vld;
    logic [DATA_W-1:0] tx_byte;

    modport master (
        output din, din_vld, ovf_clr, tx_busy,
        input  full, empty, usedw, overflow, tx_byte_vld, tx_byte
    );

    modport slave (
        input  din, din_vld, ovf_clr, tx_busy,
        output full, empty, usedw, overflow, tx_byte_vld, tx_byte
    );
endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous byte FIFO with registered occupancy and a sticky overflow flag.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module uart_feeder_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              pop,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       usedw,
    output logic              overflow
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push;
    logic              drop;

    assign full   = (usedw == (AW+1)'(DEPTH));
    assign empty  = (usedw == '0);
    assign pop_ok = pop & ~empty;
    assign push   = din_vld & (~full | pop_ok);
    assign drop   = din_vld & full & ~pop_ok;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth: pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop_ok})
                2'b10:   usedw <= usedw + (AW+1)'(1);
                2'b01:   usedw <= usedw - (AW+1)'(1);
                default: usedw <= usedw;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// FIFO-backed scheduler issuing one-cycle send strobes to an idle UART TX.
// Define UART_FEEDER_HEX_ASCII_EN to send each byte as two ASCII hex chars.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_feeder_if.slave  bus
);
    logic [2:0]        state;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              vld_q;
    logic [DATA_W-1:0] byte_q;
`ifdef UART_FEEDER_HEX_ASCII_EN
    logic [3:0]        lo_nib;
`endif

    uart_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (bus.din),
        .din_vld  (bus.din_vld),
        .pop      (pop),
        .ovf_clr  (bus.ovf_clr),
        .head     (head),
        .full     (bus.full),
        .empty    (bus.empty),
        .usedw    (bus.usedw),
        .overflow (bus.overflow)
    );

    assign pop             = (state == ST_IDLE) & ~bus.empty & ~bus.tx_busy;
    assign bus.tx_byte_vld = vld_q;
    assign bus.tx_byte     = byte_q;

    // SEND never looks at tx_busy: the strobe itself holds busy high that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vld_q  <= 1'b0;
            byte_q <= '0;
`ifdef UART_FEEDER_HEX_ASCII_EN
            lo_nib <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state  <= ST_SEND;
                        vld_q  <= 1'b1;
`ifdef UART_FEEDER_HEX_ASCII_EN
                        byte_q <= DATA_W'(hex_char(head[7:4]));
                        lo_nib <= head[3:0];
`else
                        byte_q <= head;
`endif
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                    vld_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!bus.tx_busy) begin
`ifdef UART_FEEDER_HEX_ASCII_EN
                        state  <= ST_SEND_LO;
                        vld_q  <= 1'b1;
                        byte_q <= DATA_W'(hex_char(lo_nib));
`else
                        state  <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_FEEDER_HEX_ASCII_EN
                ST_SEND_LO: begin
                    state <= ST_WAIT_LO;
                    vld_q <= 1'b0;
                end
                ST_WAIT_LO: begin
                    if (!bus.tx_busy) state <= ST_IDLE;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple busy-frame transmitter model.
module tb_uart_tx_feeder;

    localparam int FRAME = 12;
`ifdef UART_FEEDER_HEX_ASCII_EN
    localparam int CH = 2;
`else
    localparam int CH = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic hold_busy;
    int   frame_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DATA_W(8), .AW(4)) bus ();

    uart_tx_feeder #(.DATA_W(8), .DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Transmitter model: busy on the strobe itself, then for a frame
    assign bus.tx_busy = bus.tx_byte_vld | (frame_cnt != 0) | hold_busy;

    always @(posedge clk) begin
        if (bus.tx_byte_vld)  frame_cnt <= FRAME;
        else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
    end

    int         vectors = 0;
    int         miscompares = 0;
    int         pulses = 0;
    logic [7:0] exp_q[$];
    logic       prev_busy = 1'b0;
    logic       prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        logic [7:0] tbl [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                 8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tbl[n];
    endfunction

    task automatic push_exp(input logic [7:0] b);
`ifdef UART_FEEDER_HEX_ASCII_EN
        exp_q.push_back(asc(b[7:4]));
        exp_q.push_back(asc(b[3:0]));
`else
        exp_q.push_back(b);
`endif
    endtask

    // Monitor: every strobe pops one expected character
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_byte_vld) begin
                pulses++;
                chk("strobe_after_busy", {31'd0, prev_busy}, 32'd0);
                chk("strobe_width", {31'd0, prev_vld}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got tx_byte 0x%0h, expected no strobe", bus.tx_byte);
                end else begin
                    chk("tx_byte", {24'd0, bus.tx_byte}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_busy <= bus.tx_busy;
            prev_vld  <= bus.tx_byte_vld;
        end else begin
            prev_busy <= 1'b0;
            prev_vld  <= 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.din     = b;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_full"},     {31'd0, bus.full},        32'd0);
        chk({tag, "_empty"},    {31'd0, bus.empty},       32'd1);
        chk({tag, "_usedw"},    {27'd0, bus.usedw},       32'd0);
        chk({tag, "_overflow"}, {31'd0, bus.overflow},    32'd0);
        chk({tag, "_vld"},      {31'd0, bus.tx_byte_vld}, 32'd0);
        chk({tag, "_tx_byte"},  {24'd0, bus.tx_byte},     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        logic [7:0] a5_first;
        rst_n       = 1'b0;
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.ovf_clr = 1'b0;
        hold_busy   = 1'b0;
        tick(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Single byte, idle transmitter: strobe two cycles after the write edge
`ifdef UART_FEEDER_HEX_ASCII_EN
        a5_first = 8'h41;
`else
        a5_first = 8'hA5;
`endif
        push_exp(8'hA5);
        bus.din     = 8'hA5;
        bus.din_vld = 1'b1;
        @(posedge clk);
        #1 bus.din_vld = 1'b0;
        @(negedge clk);
        chk("lat_no_strobe_yet", {31'd0, bus.tx_byte_vld}, 32'd0);
        chk("lat_usedw_1", {27'd0, bus.usedw}, 32'd1);
        @(negedge clk);
        chk("lat_strobe", {31'd0, bus.tx_byte_vld}, 32'd1);
        chk("lat_tx_byte", {24'd0, bus.tx_byte}, {24'd0, a5_first});
        chk("lat_empty_after_pop", {31'd0, bus.empty}, 32'd1);
        @(negedge clk);
        chk("lat_strobe_one_cycle", {31'd0, bus.tx_byte_vld}, 32'd0);
        chk("lat_tx_byte_held", {24'd0, bus.tx_byte}, {24'd0, a5_first});
        wait_drain("drain_a5", 100);
        tick(20);

        // Three bytes held off by a long busy period
        hold_busy = 1'b1;
        tick();
        write_byte(8'h01); push_exp(8'h01);
        write_byte(8'h02); push_exp(8'h02);
        write_byte(8'h03); push_exp(8'h03);
        p0 = pulses;
        tick(100);
        chk("busy_no_strobe", pulses, p0);
        chk("busy_usedw_3", {27'd0, bus.usedw}, 32'd3);
        hold_busy = 1'b0;
        wait_drain("drain_seq3", 300);
        chk("seq3_strobes", pulses - p0, 3 * CH);
        tick(20);

        // Fill to full, then a dropped write sets the sticky flag
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h10 + 8'(i));
            push_exp(8'h10 + 8'(i));
        end
        chk("fill_full", {31'd0, bus.full}, 32'd1);
        chk("fill_usedw_16", {27'd0, bus.usedw}, 32'd16);
        chk("fill_no_ovf", {31'd0, bus.overflow}, 32'd0);
        write_byte(8'hFF);
        chk("drop_ovf_set", {31'd0, bus.overflow}, 32'd1);
        chk("drop_usedw_16", {27'd0, bus.usedw}, 32'd16);
        tick(3);
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

        // Write into a full FIFO on the same edge as a pop
        hold_busy   = 1'b0;
        bus.din     = 8'h5A;
        bus.din_vld = 1'b1;
        push_exp(8'h5A);
        tick();
        bus.din_vld = 1'b0;
        chk("pushpop_usedw_16", {27'd0, bus.usedw}, 32'd16);
        chk("pushpop_full", {31'd0, bus.full}, 32'd1);
        chk("pushpop_no_ovf", {31'd0, bus.overflow}, 32'd0);
        wait_drain("drain_fill17", 17 * CH * (FRAME + 6) + 50);
        tick(20);

        // Reset while waiting on the transmitter with 4 bytes buffered
`ifdef UART_FEEDER_HEX_ASCII_EN
        exp_q.push_back(8'h32);
`else
        exp_q.push_back(8'h21);
`endif
        for (int i = 0; i < 5; i++) write_byte(8'h21 + 8'(i));
        tick(4);
        chk("prereset_usedw_4", {27'd0, bus.usedw}, 32'd4);
        chk("prereset_sent", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        p0 = pulses;
        tick(30);
        chk("postrst_no_strobe", pulses, p0);
        chk("postrst_usedw", {27'd0, bus.usedw}, 32'd0);

`ifdef UART_FEEDER_HEX_ASCII_EN
        // One byte becomes two characters from a single pop
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h43);
        p0 = pulses;
        write_byte(8'h3C);
        tick(3);
        chk("hex_single_pop", {27'd0, bus.usedw}, 32'd0);
        wait_drain("drain_hex", 100);
        chk("hex_two_strobes", pulses - p0, 2);
`endif

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
